// File: rtl/video_crush_multi.sv
// ---------------------------------------------------------------------------
// video_crush_multi
//
// Posteriser ("bit-crush") stage for the video effects chain. Each of NCH
// channels (CW bits, channel 0 in the LSBs) is quantised to a step Q that is
// derived from the pressure input. Q and its fixed-point reciprocal R are
// recomputed once per frame by an iterative restoring divider. The update
// starts when the raster reaches (TRIG_H, TRIG_V), so the step never changes
// part-way through a frame. The counts and the active flag are delayed so
// they stay aligned with the crushed pixel (3 cycles).
//
// Optional feature: define VIDEO_CRUSH_MULTI_DITHER_EN to add a 2^DB x 2^DB
// ordered (Bayer) dither ahead of the quantiser. When it is undefined the
// dither term is zero (plain truncation) and DB is only range-checked.
//
// Ports:
//   clk              pixel clock
//   rst              asynchronous, active-high reset
//   h_count_in       horizontal raster count (11 bits)
//   v_count_in       vertical raster count (10 bits)
//   active_draw_in   active-region flag
//   pixel_in         input pixel, NCH*CW bits
//   pressure         effect amount (10 bits), sampled only on the trigger
//   h_count_out      h_count_in delayed 3 cycles
//   v_count_out      v_count_in delayed 3 cycles
//   active_draw_out  active_draw_in delayed 3 cycles
//   pixel_out        crushed pixel, aligned with the count outputs
//   busy             high while the Q/R update is in progress
// ---------------------------------------------------------------------------
module video_crush_multi #(
    parameter int NCH    = 3,
    parameter int CW     = 8,
    parameter int DB     = 2,
    parameter int TRIG_H = 80,
    parameter int TRIG_V = 721
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       h_count_in,
    input  logic [9:0]        v_count_in,
    input  logic              active_draw_in,
    input  logic [NCH*CW-1:0] pixel_in,
    input  logic [9:0]        pressure,
    output logic [10:0]       h_count_out,
    output logic [9:0]        v_count_out,
    output logic              active_draw_out,
    output logic [NCH*CW-1:0] pixel_out,
    output logic              busy
);

    // F fractional bits make floor(t*R >> F) == floor(t/Q) exact, because
    // t*Q < 2^(2*CW+1) for every legal t and Q.
    localparam int F     = 2 * CW + 1;
    localparam int PIXW  = NCH * CW;
    localparam int QW    = CW + 1;          // Q in 1..2^CW
    localparam int RW    = F + 1;           // R in 1..2^F
    localparam int TW    = CW + 1;          // pixel + dither
    localparam int PW    = TW + RW;         // t * R
    localparam int KW    = PW - F;          // quotient estimate k
    localparam int MW    = KW + QW;         // k * Q before saturation
    localparam int REMW  = CW + 2;          // divider partial remainder
    localparam int CNT_W = $clog2(F + 1);

    if (CW < 4 || CW > 10) begin : g_bad_cw
        $error("video_crush_multi: CW must lie in 4..10");
    end
    if (DB < 1 || DB > 4) begin : g_bad_db
        $error("video_crush_multi: DB must lie in 1..4");
    end

    function automatic logic [CW-1:0] sat_cw(input logic [MW-1:0] v);
        if (v > MW'((1 << CW) - 1)) begin
            sat_cw = '1;
        end else begin
            sat_cw = CW'(v);
        end
    endfunction

    // -----------------------------------------------------------------------
    // Per-frame Q/R update: three-process FSM plus divider datapath
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             trig_hit;
    logic             load;
    logic             div_step;
    logic             commit;
    logic [QW-1:0]    qn_calc;
    logic [QW-1:0]    qn;
    logic [QW-1:0]    q_reg;
    logic [RW-1:0]    r_reg;
    logic [RW-1:0]    quo;
    logic [REMW-1:0]  rem;
    logic [REMW-1:0]  rem_sh;
    logic             div_ge;
    logic [CNT_W-1:0] cnt;

    assign trig_hit = (h_count_in == 11'(TRIG_H)) && (v_count_in == 10'(TRIG_V));
    assign qn_calc  = QW'(pressure >> (10 - CW)) + QW'(1);

    // The dividend is 2^F: its only set bit enters on the first RUN cycle.
    assign rem_sh = REMW'({rem, (cnt == CNT_W'(F))});
    assign div_ge = (rem_sh >= REMW'(qn));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trig_hit) state_nxt = RUN;
            RUN:     if (cnt == '0) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        load     = 1'b0;
        div_step = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: load = trig_hit;
            RUN: begin
                busy     = 1'b1;
                div_step = 1'b1;
            end
            COMMIT: begin
                busy   = 1'b1;
                commit = 1'b1;
            end
            default: ;
        endcase
    end

    // Q and R change together in the single COMMIT cycle, so a pixel
    // sampling them in S2 never sees a mismatched pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qn    <= QW'(1);
            rem   <= '0;
            quo   <= '0;
            cnt   <= '0;
            q_reg <= QW'(1);
            r_reg <= {1'b1, {F{1'b0}}};
        end else begin
            if (load) begin
                qn  <= qn_calc;
                rem <= '0;
                quo <= '0;
                cnt <= CNT_W'(F);
            end
            if (div_step) begin
                rem <= div_ge ? (rem_sh - REMW'(qn)) : rem_sh;
                quo <= {quo[RW-2:0], div_ge};
                cnt <= cnt - CNT_W'(1);
            end
            if (commit) begin
                q_reg <= qn;
                r_reg <= quo + RW'(rem != '0);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Dither term, taken from the count outputs
    // -----------------------------------------------------------------------
    logic [QW-1:0] dith;

`ifdef VIDEO_CRUSH_MULTI_DITHER_EN
    localparam int DPW = 2 * DB + QW;

    // Bit-reversed interleave of (x^y) and y yields the Bayer ordering.
    function automatic logic [2*DB-1:0] bayer_idx(input logic [DB-1:0] x,
                                                  input logic [DB-1:0] y);
        logic [2*DB-1:0] il;
        logic [DB-1:0]   xy;
        xy = x ^ y;
        for (int i = 0; i < DB; i++) begin
            il[2*i+1] = xy[i];
            il[2*i]   = y[i];
        end
        for (int i = 0; i < 2 * DB; i++) begin
            bayer_idx[i] = il[2*DB-1-i];
        end
    endfunction

    logic [2*DB-1:0] draw;
    logic [DPW-1:0]  dprod;

    always_comb begin
        draw  = bayer_idx(h_count_out[DB:1], v_count_out[DB:1]);
        dprod = DPW'(draw) * DPW'(q_reg);
        dith  = QW'(dprod >> (2 * DB));
    end
`else
    assign dith = '0;
`endif

    // -----------------------------------------------------------------------
    // S1: register the incoming pixel and raster position
    // -----------------------------------------------------------------------
    logic [PIXW-1:0] pix_p0;
    logic [10:0]     h_p0;
    logic [9:0]      v_p0;
    logic            vld_p0;

    always_ff @(posedge clk) begin
        pix_p0 <= pixel_in;
        h_p0   <= h_count_in;
        v_p0   <= v_count_in;
    end

    // -----------------------------------------------------------------------
    // S2: add dither, multiply by R; Q is captured alongside for S3
    // -----------------------------------------------------------------------
    logic [10:0]     h_p1;
    logic [9:0]      v_p1;
    logic            vld_p1;
    logic [QW-1:0]   q_p1;
    logic [PIXW-1:0] pix_res;

    always_ff @(posedge clk) begin
        h_p1 <= h_p0;
        v_p1 <= v_p0;
        q_p1 <= q_reg;
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [TW-1:0] t;
        logic [PW-1:0] prod_p1;
        logic [KW-1:0] k;
        logic [MW-1:0] m;

        assign t = TW'(pix_p0[c*CW +: CW]) + dith;

        always_ff @(posedge clk) begin
            prod_p1 <= PW'(t) * PW'(r_reg);
        end

        // S3 arithmetic: k = floor(t/Q), then back to a level and clamp.
        assign k = KW'(prod_p1 >> F);
        assign m = MW'(k) * MW'(q_p1);
        assign pix_res[c*CW +: CW] = sat_cw(m);
    end

    // -----------------------------------------------------------------------
    // S3: output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0          <= 1'b0;
            vld_p1          <= 1'b0;
            active_draw_out <= 1'b0;
            h_count_out     <= '0;
            v_count_out     <= '0;
            pixel_out       <= '0;
        end else begin
            vld_p0          <= active_draw_in;
            vld_p1          <= vld_p0;
            active_draw_out <= vld_p1;
            h_count_out     <= h_p1;
            v_count_out     <= v_p1;
            pixel_out       <= pix_res;
        end
    end

endmodule
